beta_writeback: RTL

//  Writeback stage sitting directly upstream of the register file write port.

---
 rtl/beta_pkg.sv | 20 ++
 rtl/beta_writeback_if.sv | 31 +++
 rtl/beta_load_align.sv | 29 ++
 rtl/beta_writeback.sv | 78 +++++++
 4 files changed

// File: rtl/beta_pkg.sv
// Shared types for the beta writeback stage: datapath width, load encodings and the write request.
package beta_pkg;

  localparam int unsigned XLEN = 32;

  // Enumerator values match the RISC-V load funct3 encodings.
  typedef enum logic [2:0] {
    Lb  = 3'b000,
    Lh  = 3'b001,
    Lw  = 3'b010,
    Lbu = 3'b100,
    Lhu = 3'b101
  } load_type_e;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/beta_writeback_if.sv
// Handshake bundle between the ALU/LSU result producers, the writeback stage and the regfile port.
interface beta_writeback_if;
  import beta_pkg::*;

  logic            alu_valid_i;
  logic            alu_ready_o;
  logic [4:0]      alu_rd_addr_i;
  logic [XLEN-1:0] alu_wdata_i;
  logic            lsu_valid_i;
  logic            lsu_ready_o;
  logic [4:0]      lsu_rd_addr_i;
  logic [31:0]     lsu_rdata_i;
  logic [2:0]      lsu_funct3_i;
  logic [1:0]      lsu_byte_off_i;
  logic            rf_wr_en_o;
  logic [4:0]      rf_rd_addr_o;
  logic [XLEN-1:0] rf_wdata_o;

  modport master (
    output alu_valid_i, alu_rd_addr_i, alu_wdata_i,
    output lsu_valid_i, lsu_rd_addr_i, lsu_rdata_i, lsu_funct3_i, lsu_byte_off_i,
    input  alu_ready_o, lsu_ready_o, rf_wr_en_o, rf_rd_addr_o, rf_wdata_o
  );

  modport slave (
    input  alu_valid_i, alu_rd_addr_i, alu_wdata_i,
    input  lsu_valid_i, lsu_rd_addr_i, lsu_rdata_i, lsu_funct3_i, lsu_byte_off_i,
    output alu_ready_o, lsu_ready_o, rf_wr_en_o, rf_rd_addr_o, rf_wdata_o
  );

endinterface

// File: rtl/beta_load_align.sv
// Combinational load extraction: selects the byte/half addressed by the load and extends it.
module beta_load_align
  import beta_pkg::*;
(
  input  logic [31:0]     rdata_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      byte_off_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{byte_off_i, 3'b000} +: 8];
  // Halfword loads are aligned upstream, so only the upper offset bit picks the half.
  assign half_sel = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    data_o = rdata_i;
    case (load_type_e'(funct3_i))
      Lb:      data_o = {{24{byte_sel[7]}}, byte_sel};
      Lbu:     data_o = {24'd0, byte_sel};
      Lh:      data_o = {{16{half_sel[15]}}, half_sel};
      Lhu:     data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/beta_writeback.sv
// Writeback stage: LSU-priority merge of ALU/load results into one registered regfile write.
// Define BETA_WB_BYPASS_EN to forward the in-flight write onto the decode read data.
module beta_writeback
  import beta_pkg::*;
#(
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  beta_writeback_if.slave      wb,
`ifdef BETA_WB_BYPASS_EN
  input  logic [4:0]           rs1_addr_i,
  input  logic [4:0]           rs2_addr_i,
  input  logic [XLEN-1:0]      rf_rs1_data_i,
  input  logic [XLEN-1:0]      rf_rs2_data_i,
  output logic [XLEN-1:0]      rs1_data_o,
  output logic [XLEN-1:0]      rs2_data_o,
`endif
  output logic [INSTRET_W-1:0] instret_o
);

  logic                 lsu_acc;
  logic                 alu_acc;
  logic                 accept;
  logic [XLEN-1:0]      load_data;
  wb_req_t              req_d, req_q;
  logic                 wr_en_q;
  logic [INSTRET_W-1:0] instret_q;

  beta_load_align u_load_align (
    .rdata_i    (wb.lsu_rdata_i),
    .funct3_i   (wb.lsu_funct3_i),
    .byte_off_i (wb.lsu_byte_off_i),
    .data_o     (load_data)
  );

  assign wb.lsu_ready_o = !rst_i;
  assign wb.alu_ready_o = !rst_i && !wb.lsu_valid_i;

  assign lsu_acc = wb.lsu_valid_i && wb.lsu_ready_o;
  assign alu_acc = wb.alu_valid_i && wb.alu_ready_o;
  assign accept  = lsu_acc || alu_acc;

  always_comb begin
    req_d = '{rd: wb.alu_rd_addr_i, wdata: wb.alu_wdata_i};
    if (lsu_acc) begin
      req_d = '{rd: wb.lsu_rd_addr_i, wdata: load_data};
    end
  end

  // x0 writes still retire and count; only the regfile enable is suppressed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_en_q   <= 1'b0;
      req_q     <= '0;
      instret_q <= '0;
    end else begin
      wr_en_q <= accept && (req_d.rd != 5'd0);
      if (accept) begin
        req_q     <= req_d;
        instret_q <= instret_q + 1'b1;
      end
    end
  end

  assign wb.rf_wr_en_o   = wr_en_q;
  assign wb.rf_rd_addr_o = req_q.rd;
  assign wb.rf_wdata_o   = req_q.wdata;
  assign instret_o       = instret_q;

`ifdef BETA_WB_BYPASS_EN
  assign rs1_data_o = (wr_en_q && (req_q.rd == rs1_addr_i) && (rs1_addr_i != 5'd0)) ?
                      req_q.wdata : rf_rs1_data_i;
  assign rs2_data_o = (wr_en_q && (req_q.rd == rs2_addr_i) && (rs2_addr_i != 5'd0)) ?
                      req_q.wdata : rf_rs2_data_i;
`endif

endmodule
